rvv_backend_vrf_group_reader: RTL

//  Read-side companion of the 32-entry vector register file.

---
 rtl/rvv_vrf_rd_pkg.sv | 34 +++
 rtl/rvv_backend_vrf_rd_fifo.sv | 64 ++++++
 rtl/rvv_backend_vrf_group_reader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rvv_vrf_rd_pkg.sv
// Shared types and constants for the VRF group reader: EMUL encoding, beat record, FSM states.
`ifndef VLEN
  `define VLEN 64
`endif

package rvv_vrf_rd_pkg;

  localparam int VRF_VLEN  = `VLEN;
  localparam int VRF_TAG_W = 4;
  localparam int NREG_VRF  = 32;

  typedef enum logic [1:0] {EMUL1, EMUL2, EMUL4, EMUL8} emul_e;

  typedef enum logic {IDLE, BUSY} rd_state_e;

  typedef struct packed {
    logic [VRF_VLEN-1:0]  data;
    logic [2:0]           idx;
    logic                 last;
    logic                 err;
    logic [VRF_TAG_W-1:0] tag;
  } rd_beat_t;

  // nreg-1 for a group size: 0, 1, 3, 7.
  function automatic logic [2:0] nreg_mask(emul_e emul);
    case (emul)
      EMUL1:   return 3'd0;
      EMUL2:   return 3'd1;
      EMUL4:   return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/rvv_backend_vrf_rd_fifo.sv
// Two-entry beat FIFO; head entry is presented combinationally.
module rvv_backend_vrf_rd_fifo
  import rvv_vrf_rd_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  rd_beat_t push_beat,
  input  logic     pop,
  output rd_beat_t head,
  output logic     full,
  output logic     empty
);

  rd_beat_t   mem_q [2];
  rd_beat_t   mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_beat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is reset here only because it is two entries and the idle head must read as zero.
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ASSERT_ON
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) (push && full) |-> pop);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) pop |-> !empty);
`endif

endmodule

// File: rtl/rvv_backend_vrf_group_reader.sv
// Accepts one register-group read and streams its registers, one beat per cycle, through a 2-entry buffer.
module rvv_backend_vrf_group_reader
  import rvv_vrf_rd_pkg::*;
#(
  parameter int VLEN  = VRF_VLEN,  // must match the package beat width
  parameter int TAG_W = VRF_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREG_VRF*VLEN-1:0] vreg,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [4:0]               req_vs,
  input  logic [1:0]               req_emul,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [VLEN-1:0]          rd_data,
  output logic [2:0]               rd_idx,
  output logic                     rd_last,
  output logic                     rd_err,
  output logic [TAG_W-1:0]         rd_tag
);

  rd_state_e        state_q, state_d;
  logic [4:0]       vs_q, vs_d;
  emul_e            emul_q, emul_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;
  logic [2:0]       cnt_q, cnt_d;

  logic [VLEN-1:0]  vreg_arr [NREG_VRF];
  logic [4:0]       rd_reg;
  logic             push, pop, full, empty;
  rd_beat_t         push_beat, head;

  always_comb begin
    for (int i = 0; i < NREG_VRF; i++) vreg_arr[i] = vreg[i*VLEN +: VLEN];
  end

  // Register index wraps modulo 32 by 5-bit truncation.
  assign rd_reg = vs_q + {2'b00, cnt_q};

  assign pop      = !empty && rd_ready;
  assign rd_valid = !empty;
  assign rd_data  = head.data;
  assign rd_idx   = head.idx;
  assign rd_last  = head.last;
  assign rd_err   = head.err;
  assign rd_tag   = head.tag;

  always_comb begin
    state_d   = state_q;
    vs_d      = vs_q;
    emul_d    = emul_q;
    tag_d     = tag_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    push      = 1'b0;
    push_beat = '{data: vreg_arr[rd_reg], idx: cnt_q, last: (cnt_q == nreg_mask(emul_q)),
                  err: err_q, tag: tag_q};
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          vs_d    = req_vs;
          emul_d  = emul_e'(req_emul);
          tag_d   = req_tag;
          err_d   = (req_vs[2:0] & nreg_mask(emul_e'(req_emul))) != 3'd0;
          cnt_d   = 3'd0;
          state_d = BUSY;
        end
      end
      default: begin
        if (!full || pop) begin
          push  = 1'b1;
          cnt_d = cnt_q + 3'd1;
          if (push_beat.last) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vs_q    <= '0;
      emul_q  <= EMUL1;
      tag_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_d;
      emul_q  <= emul_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  rvv_backend_vrf_rd_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

`ifdef ASSERT_ON
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (rd_valid && !rd_ready) |=> $stable({rd_valid, rd_data, rd_idx, rd_last, rd_err, rd_tag}));
  a_valid_known: assert property (@(posedge clk) !$isunknown(rd_valid));
`endif

endmodule
